// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: FSM states, owner encoding,
// block geometry and the fill address helper.
package cache_fill_arbiter_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LATENCY = 4;
  localparam int CNT_W       = 4;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Byte address of word k inside a block: base | (k << 1).
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [2:0]  k);
    return base | {12'd0, k, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Saturating up-counter used for the read-issue and read-receive counts of a fill.
module fill_counter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int W     = CNT_W,
  parameter int LIMIT = BLOCK_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = W'(LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache misses, D-cache misses and D-cache write-through stores
// onto one pipelined main-memory port, and steers returning fill words.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [15:0]       i_miss_addr,
  input  logic              d_miss,
  input  logic [15:0]       d_miss_addr,
  input  logic              d_wr_req,
  input  logic [15:0]       d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(BLOCK_WORDS);

  state_t            state;
  owner_t            owner;
  logic [15:0]       base;
  logic [DATA_W-1:0] wdata;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              in_fill;
  logic              issuing;
  logic              beat;
  logic              grant_miss;

  assign in_fill    = (state == FILL);
  assign issuing    = in_fill && (issue_cnt < ALL_WORDS);
  // Beats outside FILL or past the last word are stale and dropped here.
  assign beat       = in_fill && mem_valid && (rcv_cnt < ALL_WORDS);
  assign grant_miss = (state == IDLE) && !d_wr_req && (d_miss || i_miss);

  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant_miss),
    .en    (issuing),
    .cnt   (issue_cnt)
  );

  fill_counter u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant_miss),
    .en    (beat),
    .cnt   (rcv_cnt)
  );

  // Grants happen only in IDLE; priority is store > D miss > I miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_I;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state <= WRITE;
            base  <= d_wr_addr;
            wdata <= d_wr_data;
          end else if (d_miss) begin
            state <= FILL;
            owner <= OWN_D;
            base  <= d_miss_addr & BLOCK_MASK;
          end else if (i_miss) begin
            state <= FILL;
            owner <= OWN_I;
            base  <= i_miss_addr & BLOCK_MASK;
          end
        end
        FILL: begin
          if (beat && (rcv_cnt == LAST_WORD)) begin
            state <= DONE;
          end
        end
        WRITE:   state <= IDLE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state; rst_n forces them quiet while held in reset.
  assign busy        = rst_n && (state != IDLE);
  assign mem_wr      = rst_n && (state == WRITE);
  assign mem_en      = rst_n && (issuing || (state == WRITE));
  assign mem_addr    = !rst_n          ? 16'd0 :
                       (state == WRITE) ? base :
                       issuing          ? word_addr(base, issue_cnt[2:0]) : 16'd0;
  assign mem_wdata   = mem_wr ? wdata : '0;
  assign d_wr_ack    = mem_wr;

  assign fill_we_i   = rst_n && beat && (owner == OWN_I);
  assign fill_we_d   = rst_n && beat && (owner == OWN_D);
  assign fill_word   = rst_n ? rcv_cnt[2:0] : 3'd0;
  assign fill_data   = rst_n ? mem_rdata : '0;

  assign i_fill_done = rst_n && (state == DONE) && (owner == OWN_I);
  assign d_fill_done = rst_n && (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter: per-cycle expected timeline plus
// a fill-beat scoreboard, driven against a 4-cycle pipelined memory model.
module tb_cache_fill_arbiter;

  localparam int B_EN  = 7;
  localparam int B_WR  = 6;
  localparam int B_WEI = 5;
  localparam int B_WED = 4;
  localparam int B_IDN = 3;
  localparam int B_DDN = 2;
  localparam int B_ACK = 1;
  localparam int B_BSY = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
  logic        fill_we_i, fill_we_d;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_fill_done, d_fill_done, d_wr_ack, busy;

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .fill_we_i   (fill_we_i),
    .fill_we_d   (fill_we_d),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  function automatic logic [15:0] rdata_of(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory: a read issued in cycle k returns its data in cycle k+4.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4] = '{default: 16'h0};
  assign mem_valid = pv[3];
  assign mem_rdata = pv[3] ? rdata_of(pa[3]) : 16'h0;
  always @(posedge clk) begin
    pv <= {pv[2:0], mem_en && !mem_wr};
    for (int i = 3; i > 0; i--) pa[i] <= pa[i-1];
    pa[0] <= mem_addr;
  end

  typedef struct packed {
    logic        own;
    logic [2:0]  word;
    logic [15:0] data;
  } beat_t;

  logic [7:0]  exp_ctrl  [64];
  logic [15:0] exp_addr  [64];
  logic [15:0] exp_wdata [64];
  beat_t       beat_q [$];
  logic [15:0] i_next [$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [7:0] obs_ctrl();
    return {mem_en, mem_wr, fill_we_i, fill_we_d, i_fill_done, d_fill_done, d_wr_ack, busy};
  endfunction

  task automatic plan_clear();
    for (int c = 0; c < 64; c++) begin
      exp_ctrl[c] = '0; exp_addr[c] = '0; exp_wdata[c] = '0;
    end
    beat_q.delete();
  endtask

  // A fill granted so that cycle t0 is its first FILL cycle; cycles >= cut are not planned.
  task automatic plan_fill(input int t0, input logic own, input logic [15:0] base, input int cut);
    for (int k = 0; k < 13; k++) begin
      if (t0 + k < cut) begin
        exp_ctrl[t0+k][B_BSY] = 1'b1;
        if (k < 8) begin
          exp_ctrl[t0+k][B_EN] = 1'b1;
          exp_addr[t0+k] = base + 16'(2 * k);
        end
        if (k >= 4 && k < 12) begin
          exp_ctrl[t0+k][own ? B_WED : B_WEI] = 1'b1;
          beat_q.push_back('{own, 3'(k - 4), rdata_of(base + 16'(2 * (k - 4)))});
        end
        if (k == 12) exp_ctrl[t0+k][own ? B_DDN : B_IDN] = 1'b1;
      end
    end
  endtask

  task automatic plan_write(input int t, input logic [15:0] a, input logic [15:0] d);
    exp_ctrl[t]  = 8'b1100_0011;
    exp_addr[t]  = a;
    exp_wdata[t] = d;
  endtask

  // Requesters drop their request on completion, or present the next I-miss address.
  task automatic respond();
    if (i_fill_done) begin
      if (i_next.size() > 0) i_miss_addr = i_next.pop_front();
      else i_miss = 1'b0;
    end
    if (d_fill_done) d_miss = 1'b0;
    if (d_wr_ack) d_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      n_checks++;
      if ({obs_ctrl(), mem_addr, mem_wdata, fill_word, fill_data} !== 59'd0) begin
        n_fail++;
        $display("FAIL reset_outputs c=%0d got ctrl=%b addr=%h wdata=%h word=%0d data=%h want all zero",
                 c, obs_ctrl(), mem_addr, mem_wdata, fill_word, fill_data);
      end
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctrl() !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=%b", obs_ctrl(), 8'd0);
    end
  endtask

  task automatic test_i_fill();
    beat_t b;
    plan_clear();
    plan_fill(0, 1'b0, 16'h0120, 99);
    i_miss_addr = 16'h0126; i_miss = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL i_fill_ctrl c=%0d got=%b want=%b", c, obs_ctrl(), exp_ctrl[c]);
      end
      if (exp_ctrl[c][B_EN]) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr[c], exp_wdata[c]}) begin
          n_fail++; $display("FAIL i_fill_addr c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wdata[c]);
        end
      end
      if (fill_we_i || fill_we_d) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_fail++; $display("FAIL i_fill_beat c=%0d got unexpected beat want none", c);
        end else begin
          b = beat_q.pop_front();
          if ({fill_we_d, fill_word, fill_data} !== b) begin
            n_fail++; $display("FAIL i_fill_beat c=%0d got=%h want=%h", c, {fill_we_d, fill_word, fill_data}, b);
          end
        end
      end
      respond();
    end
    n_checks++;
    if (beat_q.size() != 0) begin
      n_fail++; $display("FAIL i_fill_beats_left got=%0d want=0", beat_q.size());
    end
  endtask

  task automatic test_dual_miss();
    beat_t b;
    plan_clear();
    plan_fill(0, 1'b1, 16'h4000, 99);
    plan_fill(14, 1'b0, 16'h1230, 99);
    i_miss_addr = 16'h1234; i_miss = 1'b1;
    d_miss_addr = 16'h4008; d_miss = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL dual_ctrl c=%0d got=%b want=%b", c, obs_ctrl(), exp_ctrl[c]);
      end
      if (exp_ctrl[c][B_EN]) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr[c], exp_wdata[c]}) begin
          n_fail++; $display("FAIL dual_addr c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wdata[c]);
        end
      end
      if (fill_we_i || fill_we_d) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_fail++; $display("FAIL dual_beat c=%0d got unexpected beat want none", c);
        end else begin
          b = beat_q.pop_front();
          if ({fill_we_d, fill_word, fill_data} !== b) begin
            n_fail++; $display("FAIL dual_beat c=%0d got=%h want=%h", c, {fill_we_d, fill_word, fill_data}, b);
          end
        end
      end
      respond();
    end
    n_checks++;
    if (beat_q.size() != 0) begin
      n_fail++; $display("FAIL dual_beats_left got=%0d want=0", beat_q.size());
    end
  endtask

  task automatic test_write_during_fill();
    beat_t b;
    plan_clear();
    plan_fill(0, 1'b0, 16'h0800, 99);
    plan_write(14, 16'h2002, 16'hBEEF);
    i_miss_addr = 16'h0800; i_miss = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL wr_in_fill_ctrl c=%0d got=%b want=%b", c, obs_ctrl(), exp_ctrl[c]);
      end
      if (exp_ctrl[c][B_EN]) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr[c], exp_wdata[c]}) begin
          n_fail++; $display("FAIL wr_in_fill_addr c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wdata[c]);
        end
      end
      if (fill_we_i || fill_we_d) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_fail++; $display("FAIL wr_in_fill_beat c=%0d got unexpected beat want none", c);
        end else begin
          b = beat_q.pop_front();
          if ({fill_we_d, fill_word, fill_data} !== b) begin
            n_fail++; $display("FAIL wr_in_fill_beat c=%0d got=%h want=%h", c, {fill_we_d, fill_word, fill_data}, b);
          end
        end
      end
      respond();
      if (c == 1) begin
        d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
      end
    end
    n_checks++;
    if (beat_q.size() != 0) begin
      n_fail++; $display("FAIL wr_in_fill_beats_left got=%0d want=0", beat_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    beat_t b;
    plan_clear();
    plan_fill(0, 1'b0, 16'h0300, 5);
    i_miss_addr = 16'h0300; i_miss = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL rst_fill_ctrl c=%0d got=%b want=%b", c, obs_ctrl(), exp_ctrl[c]);
      end
      if (exp_ctrl[c][B_EN]) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr[c], exp_wdata[c]}) begin
          n_fail++; $display("FAIL rst_fill_addr c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wdata[c]);
        end
      end
      if (fill_we_i || fill_we_d) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_fail++; $display("FAIL rst_fill_beat c=%0d got unexpected beat want none", c);
        end else begin
          b = beat_q.pop_front();
          if ({fill_we_d, fill_word, fill_data} !== b) begin
            n_fail++; $display("FAIL rst_fill_beat c=%0d got=%h want=%h", c, {fill_we_d, fill_word, fill_data}, b);
          end
        end
      end
      respond();
      if (c == 4) begin
        rst_n = 1'b0; i_miss = 1'b0;
      end
      if (c == 5) rst_n = 1'b1;
    end
    n_checks++;
    if (beat_q.size() != 0) begin
      n_fail++; $display("FAIL rst_fill_beats_left got=%0d want=0", beat_q.size());
    end
  endtask

  task automatic test_write_then_miss();
    beat_t b;
    plan_clear();
    plan_write(0, 16'h1111, 16'h0F0F);
    plan_fill(2, 1'b1, 16'h5A50, 99);
    d_wr_addr = 16'h1111; d_wr_data = 16'h0F0F; d_wr_req = 1'b1;
    d_miss_addr = 16'h5A5E; d_miss = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL wr_miss_ctrl c=%0d got=%b want=%b", c, obs_ctrl(), exp_ctrl[c]);
      end
      if (exp_ctrl[c][B_EN]) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr[c], exp_wdata[c]}) begin
          n_fail++; $display("FAIL wr_miss_addr c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wdata[c]);
        end
      end
      if (fill_we_i || fill_we_d) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_fail++; $display("FAIL wr_miss_beat c=%0d got unexpected beat want none", c);
        end else begin
          b = beat_q.pop_front();
          if ({fill_we_d, fill_word, fill_data} !== b) begin
            n_fail++; $display("FAIL wr_miss_beat c=%0d got=%h want=%h", c, {fill_we_d, fill_word, fill_data}, b);
          end
        end
      end
      respond();
    end
    n_checks++;
    if (beat_q.size() != 0) begin
      n_fail++; $display("FAIL wr_miss_beats_left got=%0d want=0", beat_q.size());
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    plan_clear();
    plan_fill(0, 1'b0, 16'hFFF0, 99);
    plan_fill(14, 1'b0, 16'h0000, 99);
    i_next.push_back(16'h0000);
    i_miss_addr = 16'hFFF0; i_miss = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL b2b_ctrl c=%0d got=%b want=%b", c, obs_ctrl(), exp_ctrl[c]);
      end
      if (exp_ctrl[c][B_EN]) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr[c], exp_wdata[c]}) begin
          n_fail++; $display("FAIL b2b_addr c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wdata[c]);
        end
      end
      if (fill_we_i || fill_we_d) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_beat c=%0d got unexpected beat want none", c);
        end else begin
          b = beat_q.pop_front();
          if ({fill_we_d, fill_word, fill_data} !== b) begin
            n_fail++; $display("FAIL b2b_beat c=%0d got=%h want=%h", c, {fill_we_d, fill_word, fill_data}, b);
          end
        end
      end
      respond();
    end
    n_checks++;
    if (beat_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_beats_left got=%0d want=0", beat_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_dual_miss();
    test_write_during_fill();
    test_reset_mid_fill();
    test_write_then_miss();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
